// File: rtl/bus_select_encoder_if.sv
// Request/select bundle between the control unit strobes and the bus mux select.
// The master drives requests and strobes; the slave returns the registered select, grant and collision count.
interface bus_select_encoder_if #(
  parameter int N_SRC = 26,
  parameter int SEL_W = 5
);
  logic             en;
  logic [N_SRC-1:0] req;
  logic             coll_clr;
  logic [SEL_W-1:0] sel;
  logic             sel_valid;
  logic [N_SRC-1:0] grant;
  logic [7:0]       coll_cnt;

  modport master (
    output en, req, coll_clr,
    input  sel, sel_valid, grant, coll_cnt
  );

  modport slave (
    input  en, req, coll_clr,
    output sel, sel_valid, grant, coll_cnt
  );
endinterface

// File: rtl/bus_select_encoder.sv
// Registered request-to-select encoder (strict one-hot / fixed priority / round-robin); 1-cycle latency.
// No backpressure: en=0 freezes every registered output and the round-robin pointer.
module bus_select_encoder #(
  parameter int N_SRC     = 26,
  parameter int SEL_W     = 5,
  parameter int IDLE_CODE = 31,
  parameter int MODE      = 0
) (
  input logic                 clk,
  input logic                 clr,
  bus_select_encoder_if.slave bus
);

  if (N_SRC < 2 || N_SRC > 64) begin : g_bad_nsrc
    $error("bus_select_encoder: N_SRC must be in 2..64");
  end
  if ((2 ** SEL_W) <= N_SRC) begin : g_bad_selw
    $error("bus_select_encoder: SEL_W too narrow for N_SRC");
  end
  if (IDLE_CODE < N_SRC || IDLE_CODE >= (2 ** SEL_W)) begin : g_bad_idle
    $error("bus_select_encoder: IDLE_CODE must lie in N_SRC..2**SEL_W-1");
  end
  if (MODE < 0 || MODE > 2) begin : g_bad_mode
    $error("bus_select_encoder: MODE must be 0, 1 or 2");
  end

  localparam logic [SEL_W-1:0] IDLE = SEL_W'(IDLE_CODE);
  localparam logic [SEL_W:0]   NSRC_X = (SEL_W+1)'(N_SRC);
  localparam logic [SEL_W-1:0] LAST = SEL_W'(N_SRC - 1);

  function automatic logic [SEL_W-1:0] lowest(input logic [N_SRC-1:0] v);
    lowest = '0;
    for (int i = N_SRC - 1; i >= 0; i--) begin
      if (v[i]) lowest = SEL_W'(i);
    end
  endfunction

  logic [SEL_W-1:0] sel_q;
  logic             vld_q;
  logic [N_SRC-1:0] grant_q;
  logic [7:0]       coll_q;
  logic [SEL_W-1:0] ptr;

  logic             any_req;
  logic             multi;
  logic [N_SRC-1:0] rr_rot;
  logic [SEL_W-1:0] rr_off;
  logic [SEL_W:0]   rr_sum;
  logic [SEL_W-1:0] rr_idx;
  logic             win_vld;
  logic [SEL_W-1:0] win_idx;
  logic [N_SRC-1:0] grant_nxt;
  logic [SEL_W-1:0] ptr_nxt;

  assign any_req = |bus.req;
  assign multi   = $countones(bus.req) > 1;

  // Rotate so bit 0 is the pointer position; the lowest set bit is then the offset from ptr.
  assign rr_rot = N_SRC'({bus.req, bus.req} >> ptr);
  assign rr_off = lowest(rr_rot);
  assign rr_sum = {1'b0, ptr} + {1'b0, rr_off};
  assign rr_idx = (rr_sum >= NSRC_X) ? SEL_W'(rr_sum - NSRC_X) : rr_sum[SEL_W-1:0];

  always_comb begin
    win_vld = 1'b0;
    win_idx = lowest(bus.req);
    case (MODE)
      0:       win_vld = any_req & ~multi;
      1:       win_vld = any_req;
      default: begin
        win_vld = any_req;
        win_idx = rr_idx;
      end
    endcase
  end

  assign grant_nxt = win_vld ? (N_SRC'(1) << win_idx) : '0;
  assign ptr_nxt   = (win_idx == LAST) ? '0 : win_idx + 1'b1;

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      sel_q   <= IDLE;
      vld_q   <= 1'b0;
      grant_q <= '0;
      coll_q  <= '0;
      ptr     <= '0;
    end else begin
      if (bus.en) begin
        sel_q   <= win_vld ? win_idx : IDLE;
        vld_q   <= win_vld;
        grant_q <= grant_nxt;
        if (MODE == 2 && win_vld) ptr <= ptr_nxt;
      end
      // Clear beats a same-cycle collision increment, and works even with en low.
      if (bus.coll_clr) coll_q <= '0;
      else if (bus.en && multi && coll_q != 8'hff) coll_q <= coll_q + 8'd1;
    end
  end

  assign bus.sel       = sel_q;
  assign bus.sel_valid = vld_q;
  assign bus.grant     = grant_q;
  assign bus.coll_cnt  = coll_q;

endmodule

// File: tb/tb_bus_select_encoder.sv
// Directed plus randomized bench for bus_select_encoder, all three modes side by side.
// A behavioural scoreboard predicts sel/sel_valid/grant/coll_cnt for each mode.
module tb_bus_select_encoder;
  localparam int N = 26;

  logic clk = 1'b0;
  logic clr;
  logic [N-1:0] r_req;
  logic r_en, r_cc;

  int checks = 0;
  int errors = 0;

  int          exp_sel[3];
  bit          exp_vld[3];
  logic [N-1:0] exp_grant[3];
  int          exp_cnt[3];
  int          exp_ptr[3];

  always #5 clk = ~clk;

  bus_select_encoder_if #(.N_SRC(N), .SEL_W(5)) b0 ();
  bus_select_encoder_if #(.N_SRC(N), .SEL_W(5)) b1 ();
  bus_select_encoder_if #(.N_SRC(N), .SEL_W(5)) b2 ();

  assign b0.req = r_req;  assign b0.en = r_en;  assign b0.coll_clr = r_cc;
  assign b1.req = r_req;  assign b1.en = r_en;  assign b1.coll_clr = r_cc;
  assign b2.req = r_req;  assign b2.en = r_en;  assign b2.coll_clr = r_cc;

  bus_select_encoder #(.N_SRC(N), .SEL_W(5), .IDLE_CODE(31), .MODE(0)) u0 (.clk(clk), .clr(clr), .bus(b0));
  bus_select_encoder #(.N_SRC(N), .SEL_W(5), .IDLE_CODE(31), .MODE(1)) u1 (.clk(clk), .clr(clr), .bus(b1));
  bus_select_encoder #(.N_SRC(N), .SEL_W(5), .IDLE_CODE(31), .MODE(2)) u2 (.clk(clk), .clr(clr), .bus(b2));

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int m = 0; m < 3; m++) begin
      exp_sel[m] = 31; exp_vld[m] = 1'b0; exp_grant[m] = '0;
      exp_cnt[m] = 0;  exp_ptr[m] = 0;
    end
  endtask

  // Applies the rules for one rising edge using the inputs currently driven.
  task automatic model_edge();
    int pc, lo, w, idx;
    logic [N-1:0] one;
    one = 1;
    pc = 0; lo = -1;
    for (int i = 0; i < N; i++) begin
      if (r_req[i]) begin
        pc++;
        if (lo < 0) lo = i;
      end
    end
    for (int m = 0; m < 3; m++) begin
      if (r_en) begin
        w = -1;
        if (pc > 0) begin
          if (m == 0) begin
            if (pc == 1) w = lo;
          end else if (m == 1) begin
            w = lo;
          end else begin
            for (int k = 0; k < N; k++) begin
              idx = (exp_ptr[m] + k) % N;
              if (w < 0 && r_req[idx]) w = idx;
            end
          end
        end
        if (w >= 0) begin
          exp_sel[m] = w; exp_vld[m] = 1'b1; exp_grant[m] = one << w;
          if (m == 2) exp_ptr[m] = (w + 1) % N;
        end else begin
          exp_sel[m] = 31; exp_vld[m] = 1'b0; exp_grant[m] = '0;
        end
      end
      if (r_cc) exp_cnt[m] = 0;
      else if (r_en && pc > 1 && exp_cnt[m] < 255) exp_cnt[m]++;
    end
  endtask

  task automatic chk_mode(input int m, input logic [4:0] s, input logic v,
                          input logic [N-1:0] g, input logic [7:0] c);
    chk($sformatf("m%0d sel", m), s, exp_sel[m]);
    chk($sformatf("m%0d sel_valid", m), v, exp_vld[m]);
    chk($sformatf("m%0d grant", m), g, exp_grant[m]);
    chk($sformatf("m%0d coll_cnt", m), c, exp_cnt[m]);
  endtask

  task automatic check_all();
    chk_mode(0, b0.sel, b0.sel_valid, b0.grant, b0.coll_cnt);
    chk_mode(1, b1.sel, b1.sel_valid, b1.grant, b1.coll_cnt);
    chk_mode(2, b2.sel, b2.sel_valid, b2.grant, b2.coll_cnt);
  endtask

  task automatic step(input logic [N-1:0] r, input logic e, input logic cc);
    r_req = r; r_en = e; r_cc = cc;
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  task automatic do_reset();
    clr = 1'b1;
    model_reset();
    #1;
    check_all();
    @(negedge clk);
    clr = 1'b0;
  endtask

  initial begin
    logic [N-1:0] rr;
    int kind;
    r_req = '0; r_en = 1'b0; r_cc = 1'b0; clr = 1'b1;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all();
    @(negedge clk);
    clr = 1'b0;

    // Reset and one-cycle latency
    r_req = 26'h0000004; r_en = 1'b1;
    #2;
    chk("pre-edge sel", b0.sel, 31);
    chk("pre-edge sel_valid", b0.sel_valid, 0);
    step(26'h0000004, 1'b1, 1'b0);
    chk("latency sel", b0.sel, 2);
    chk("latency sel_valid", b0.sel_valid, 1);
    chk("latency grant", b0.grant, 26'h0000004);

    // Strict one-hot collisions, then clear beating an increment
    repeat (3) step(26'h0000011, 1'b1, 1'b0);
    chk("strict sel", b0.sel, 31);
    chk("strict sel_valid", b0.sel_valid, 0);
    chk("strict grant", b0.grant, 0);
    chk("strict coll_cnt", b0.coll_cnt, 3);
    step(26'h0000011, 1'b1, 1'b1);
    chk("coll_clr wins", b0.coll_cnt, 0);

    // Fixed priority
    step(26'h2000110, 1'b1, 1'b0);
    chk("prio sel", b1.sel, 4);
    chk("prio grant", b1.grant, 26'h0000010);
    chk("prio coll_cnt", b1.coll_cnt, 1);

    // Round-robin fairness from a fresh pointer
    do_reset();
    step(26'h2000101, 1'b1, 1'b0);  chk("rr sel 1", b2.sel, 0);
    step(26'h2000101, 1'b1, 1'b0);  chk("rr sel 2", b2.sel, 8);
    step(26'h2000101, 1'b1, 1'b0);  chk("rr sel 3", b2.sel, 25);
    step(26'h2000101, 1'b1, 1'b0);  chk("rr sel 4 wrap", b2.sel, 0);

    // Enable low holds everything
    step(26'h3ffffff, 1'b0, 1'b0);
    step(26'h0000080, 1'b0, 1'b0);
    chk("hold sel", b2.sel, 0);
    chk("hold grant", b2.grant, 26'h0000001);
    chk("hold coll_cnt", b2.coll_cnt, 4);

    // Saturation, then clear with en low
    repeat (300) step(26'h0000003, 1'b1, 1'b0);
    chk("sat m0", b0.coll_cnt, 255);
    chk("sat m2", b2.coll_cnt, 255);
    step(26'h0000003, 1'b0, 1'b1);
    chk("clr with en low", b1.coll_cnt, 0);

    // Async reset mid-run with ptr at 9
    do_reset();
    step(26'h0000100, 1'b1, 1'b0);
    chk("ptr9 setup sel", b2.sel, 8);
    r_req = 26'h0000201;
    @(negedge clk);
    clr = 1'b1;
    model_reset();
    #1;
    chk("async sel", b2.sel, 31);
    chk("async grant", b2.grant, 0);
    check_all();
    @(negedge clk);
    clr = 1'b0;
    step(26'h0000201, 1'b1, 1'b0);
    chk("post-reset rr sel", b2.sel, 0);

    // Randomized traffic
    for (int n = 0; n < 500; n++) begin
      kind = $urandom_range(0, 3);
      case (kind)
        0: rr = '0;
        1: begin rr = '0; rr[$urandom_range(0, N-1)] = 1'b1; end
        2: rr = N'($urandom & $urandom & $urandom);
        default: rr = N'($urandom);
      endcase
      step(rr, $urandom_range(0, 7) != 0, $urandom_range(0, 15) == 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/bus_select_encoder.md
Name: bus_select_encoder

Overview:
- Registered, parametrised successor to the datapath bus encoder. Converts N_SRC out-enable/request lines into a binary bus-mux select code, one clock after sampling.
- Selectable arbitration mode: strict one-hot, fixed priority, or round-robin. Also produces a one-hot grant vector and a saturating bus-collision counter.
- Sits between the control unit's register-out strobes and the bus multiplexer select input.

Parameters:
- N_SRC, 26: number of request/source lines (2..64).
- SEL_W, 5: select code width; must satisfy 2**SEL_W > N_SRC.
- IDLE_CODE, 31: code driven when no source is selected; must be >= N_SRC and < 2**SEL_W.
- MODE, 0: 0 = strict one-hot, 1 = fixed priority (lowest index wins), 2 = round-robin.

Ports:
- clk  input  1  system clock, rising edge.
- clr  input  1  asynchronous active-high reset.
- en  input  1  sample enable; when low, all registered outputs hold.
- req  input  N_SRC  source request / out-enable lines.
- coll_clr  input  1  synchronous clear of the collision counter.
- sel  output  SEL_W  registered select code.
- sel_valid  output  1  registered; 1 when sel names a real source.
- grant  output  N_SRC  registered one-hot of the winning source, all-zero when idle.
- coll_cnt  output  8  saturating count of sampled cycles with more than one req bit set.

Behaviour:
- Reset (clr high, asynchronous, any time): sel=IDLE_CODE, sel_valid=0, grant=0, coll_cnt=0, round-robin pointer ptr=0. Outputs stay at these values while clr is high.
- Latency: outputs reflect req sampled at the previous rising edge with en=1. No combinational path from req to any output.
- en=0: sel, sel_valid, grant, ptr and coll_cnt all hold. coll_clr is still honoured.
- Winner selection on a rising edge with en=1 (popcount = number of set req bits):
  - popcount=0: all modes give sel=IDLE_CODE, sel_valid=0, grant=0; ptr unchanged.
  - MODE 0: popcount=1 gives sel=index, sel_valid=1, grant=req. popcount>1 gives the idle outputs (same as predecessor default).
  - MODE 1: winner is the lowest set index, regardless of popcount.
  - MODE 2: winner is the first set index scanning upward from ptr, wrapping N_SRC-1 to 0. On a grant, ptr <= (winner+1) mod N_SRC; winner N_SRC-1 wraps ptr to 0.
- Collision: en=1 and popcount>1 increments coll_cnt, in every mode. coll_cnt saturates at 255.
- Counter priority: coll_clr=1 forces coll_cnt to 0 on the next edge, and wins over a simultaneous collision increment.
- sel and sel_valid are always consistent: sel_valid=1 implies sel<N_SRC and grant has exactly bit sel set.
- Widths: index is zero-extended to SEL_W. req bits at or above N_SRC do not exist.
- Illegal parameter combinations (IDLE_CODE<N_SRC, 2**SEL_W<=N_SRC, MODE>2) must be rejected at elaboration.
- clr asserted mid-sequence: ptr returns to 0, so the next round-robin scan starts at index 0.

Test Plan:
- Reset/latency: clr pulse, then MODE 0 with req=0x0000004 and en=1 → one edge later sel=2, sel_valid=1, grant=0x0000004. Before that edge: sel=31, sel_valid=0.
- Strict collision: MODE 0, req=0x0000011 for 3 edges → sel=31, sel_valid=0, grant=0, coll_cnt=3. Then coll_clr=1 together with a collision → coll_cnt=0.
- Priority: MODE 1, req=0x2000110 → sel=4, grant=0x0000010, coll_cnt increments by 1.
- Round-robin fairness: MODE 2, req=0x2000101 held for 4 edges → sel sequence 0, 8, 25, 0; ptr wraps from 26 to 0.
- Enable hold and saturation:
  - en=0 while req changes → all outputs unchanged.
  - 300 collision cycles with en=1 → coll_cnt=255.
- Async reset mid-run: MODE 2 with ptr=9, assert clr between edges → outputs go to reset values immediately. After release, req=0x0000201 gives sel=0.
